memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 35 +++
 rtl/memory_stage.sv | 104 ++++++++++
 tb/tb_memory_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared pipeline structs for the EX/MEM boundary and the MEM/WB result,
// plus a helper that decides whether a captured instruction touches memory.
package memory_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic              valid;
        logic              halt;
        logic              RegWr;
        logic [REG_W-1:0]  wsel;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] store_data;
        logic              MemRead;
        logic              MemWrite;
        logic              MemToReg;
    } execute_t;

    typedef struct packed {
        logic              valid;
        logic              halt;
        logic              RegWr;
        logic [REG_W-1:0]  wsel;
        logic              MemToReg;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] dload;
    } memory_t;

    // A live, non-halt instruction with a read or write needs a cache access.
    function automatic logic mem_request(input execute_t e);
        return e.valid & ~e.halt & (e.MemRead | e.MemWrite);
    endfunction

endpackage

// File: rtl/memory_stage.sv
// Pipeline memory stage: EX/MEM register, a small access FSM that holds the
// pipeline (via mem_busy) until the data cache answers, and the MEM/WB result.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  execute_t    execute_p,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] dmemload,
    output memory_t     memory_p,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    execute_t    r_ex_q;
    execute_t    w_ex_next;
    logic [31:0] r_dload_q;
    logic [31:0] w_dload_next;
    logic        w_in_req;
    logic        w_adv;

    assign w_in_req = (r_state == REQ);
    assign w_adv    = ihit & ~stall & ~w_in_req;

    // Next-state: capture on advance (IDLE/DONE), wait for dhit in REQ.
    always_comb begin
        w_state_next = r_state;
        w_ex_next    = r_ex_q;
        w_dload_next = r_dload_q;
        case (r_state)
            IDLE, DONE: begin
                if (w_adv) begin
                    w_ex_next    = flush ? '0 : execute_p;
                    w_state_next = mem_request(w_ex_next) ? REQ : IDLE;
                end
            end
            REQ: begin
                if (dhit) begin
                    w_dload_next = dmemload;
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, EX/MEM and load registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_ex_q    <= '0;
            r_dload_q <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ex_q    <= w_ex_next;
            r_dload_q <= w_dload_next;
        end
    end

    // Cache request outputs are only driven while an access is outstanding.
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        mem_busy  = 1'b0;
        if (w_in_req) begin
            dmemREN   = r_ex_q.MemRead;
            dmemWEN   = r_ex_q.MemWrite;
            dmemaddr  = r_ex_q.alu_out;
            dmemstore = r_ex_q.store_data;
            mem_busy  = 1'b1;
        end
    end

    // Stage result straight from registers; hidden while the access is pending.
    always_comb begin
        memory_p.valid    = r_ex_q.valid & ~w_in_req;
        memory_p.halt     = r_ex_q.halt;
        memory_p.RegWr    = r_ex_q.RegWr;
        memory_p.wsel     = r_ex_q.wsel;
        memory_p.MemToReg = r_ex_q.MemToReg;
        memory_p.alu_out  = r_ex_q.alu_out;
        memory_p.dload    = r_dload_q;
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against
// a behavioural model of the stage.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        CLK;
    logic        nRST;
    execute_t    execute_p;
    logic        ihit, dhit, flush, stall;
    logic [31:0] dmemload;
    memory_t     memory_p;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        mem_busy;

    int n_checks = 0;
    int n_pass   = 0;

    memory_stage dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .execute_p (execute_p),
        .ihit      (ihit),
        .dhit      (dhit),
        .flush     (flush),
        .stall     (stall),
        .dmemload  (dmemload),
        .memory_p  (memory_p),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .mem_busy  (mem_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The stage either holds an instruction with no access pending, or holds
    // one whose cache access is still pending.
    execute_t    m_ex;
    logic [31:0] m_dload;
    bit          m_pend  = 0;
    bit          m_ready = 0;

    always @(posedge CLK) begin
        if (!nRST) begin
            m_ex    = '0;
            m_dload = '0;
            m_pend  = 0;
            m_ready = 1;
        end else if (m_ready) begin
            if (m_pend) begin
                if (dhit) begin
                    m_dload = dmemload;
                    m_pend  = 0;
                end
            end else if (ihit && !stall) begin
                m_ex   = flush ? execute_t'('0) : execute_p;
                m_pend = m_ex.valid && !m_ex.halt && (m_ex.MemRead || m_ex.MemWrite);
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge CLK) begin
        if (m_ready) begin
            memory_t exp_m;
            exp_m.valid    = m_ex.valid && !m_pend;
            exp_m.halt     = m_ex.halt;
            exp_m.RegWr    = m_ex.RegWr;
            exp_m.wsel     = m_ex.wsel;
            exp_m.MemToReg = m_ex.MemToReg;
            exp_m.alu_out  = m_ex.alu_out;
            exp_m.dload    = m_dload;
            chk("model_memory_p", 128'(memory_p), 128'(exp_m));
            chk("model_dmemREN", 128'(dmemREN), 128'(m_pend && m_ex.MemRead));
            chk("model_dmemWEN", 128'(dmemWEN), 128'(m_pend && m_ex.MemWrite));
            chk("model_dmemaddr", 128'(dmemaddr), 128'(m_pend ? m_ex.alu_out : 32'd0));
            chk("model_dmemstore", 128'(dmemstore), 128'(m_pend ? m_ex.store_data : 32'd0));
            chk("model_mem_busy", 128'(mem_busy), 128'(m_pend));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic execute_t mk(input bit rd, input bit wr, input bit hlt,
                                    input logic [31:0] alu, input logic [31:0] sd,
                                    input logic [4:0] ws);
        execute_t e;
        e            = '0;
        e.valid      = 1'b1;
        e.halt       = hlt;
        e.RegWr      = rd | (!wr && !hlt);
        e.wsel       = ws;
        e.alu_out    = alu;
        e.store_data = sd;
        e.MemRead    = rd;
        e.MemWrite   = wr;
        e.MemToReg   = rd;
        return e;
    endfunction

    function automatic execute_t rand_ex();
        execute_t e;
        int k;
        e.valid      = ($urandom_range(0, 3) != 0);
        e.halt       = ($urandom_range(0, 15) == 0);
        e.RegWr      = 1'($urandom);
        e.wsel       = 5'($urandom);
        e.alu_out    = $urandom;
        e.store_data = $urandom;
        k            = e.halt ? 0 : int'($urandom_range(0, 2));
        e.MemRead    = (k == 1);
        e.MemWrite   = (k == 2);
        e.MemToReg   = (k == 1);
        return e;
    endfunction

    task automatic rand_inputs();
        execute_p = rand_ex();
        ihit      = ($urandom_range(0, 4) != 0);
        stall     = ($urandom_range(0, 4) == 0);
        flush     = ($urandom_range(0, 9) == 0);
        dhit      = ($urandom_range(0, 9) < 4);
        dmemload  = $urandom;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_memory_p"}, 128'(memory_p), 128'(0));
        chk({tag, "_dmemREN"}, 128'(dmemREN), 128'(0));
        chk({tag, "_dmemWEN"}, 128'(dmemWEN), 128'(0));
        chk({tag, "_dmemaddr"}, 128'(dmemaddr), 128'(0));
        chk({tag, "_dmemstore"}, 128'(dmemstore), 128'(0));
        chk({tag, "_mem_busy"}, 128'(mem_busy), 128'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset with random inputs for two cycles.
        nRST = 1'b0;
        rand_inputs();
        step();
        rand_inputs();
        step();
        all_zero("reset");

        nRST = 1'b1; ihit = 1; stall = 0; flush = 0; dhit = 0; dmemload = '0;

        // Load: ALU op then lw @0x100, dhit after 3 waiting cycles.
        execute_p = mk(0, 0, 0, 32'd5, 32'd0, 5'd1);
        step();
        chk("alu_valid", 128'(memory_p.valid), 128'(1));
        chk("alu_out", 128'(memory_p.alu_out), 128'(5));
        execute_p = mk(1, 0, 0, 32'h100, 32'd0, 5'd2);
        step();
        execute_p = '0;
        for (int c = 0; c < 4; c++) begin
            chk("load_ren", 128'(dmemREN), 128'(1));
            chk("load_addr", 128'(dmemaddr), 128'(32'h100));
            chk("load_busy", 128'(mem_busy), 128'(1));
            chk("load_hidden", 128'(memory_p.valid), 128'(0));
            dhit     = (c == 3);
            dmemload = (c == 3) ? 32'hDEADBEEF : 32'h0;
            step();
        end
        chk("load_dload", 128'(memory_p.dload), 128'(32'hDEADBEEF));
        chk("load_valid", 128'(memory_p.valid), 128'(1));
        chk("load_ren_off", 128'(dmemREN), 128'(0));

        // Store: sw @0x40 data 0x1234, dhit on first request cycle.
        dhit = 0;
        execute_p = mk(0, 1, 0, 32'h40, 32'h1234, 5'd0);
        step();
        chk("store_wen", 128'(dmemWEN), 128'(1));
        chk("store_addr", 128'(dmemaddr), 128'(32'h40));
        chk("store_data", 128'(dmemstore), 128'(32'h1234));
        chk("store_ren", 128'(dmemREN), 128'(0));
        execute_p = '0;
        dhit = 1;
        step();
        chk("store_wen_once", 128'(dmemWEN), 128'(0));
        chk("store_busy_off", 128'(mem_busy), 128'(0));

        // Flush on advance turns a lw into a bubble.
        dhit = 0;
        execute_p = mk(1, 0, 0, 32'h80, 32'd0, 5'd4);
        flush = 1;
        step();
        chk("flush_ren", 128'(dmemREN), 128'(0));
        chk("flush_valid", 128'(memory_p.valid), 128'(0));
        chk("flush_busy", 128'(mem_busy), 128'(0));
        // Flush during an outstanding access is ignored.
        flush = 0;
        step();
        chk("flushreq_ren0", 128'(dmemREN), 128'(1));
        flush = 1;
        step();
        chk("flushreq_ren1", 128'(dmemREN), 128'(1));
        chk("flushreq_addr", 128'(dmemaddr), 128'(32'h80));
        flush = 0; dhit = 1; dmemload = 32'hCAFEF00D; execute_p = '0;
        step();
        chk("flushreq_dload", 128'(memory_p.dload), 128'(32'hCAFEF00D));
        chk("flushreq_valid", 128'(memory_p.valid), 128'(1));

        // Halt passes through with no request.
        dhit = 0;
        execute_p = mk(0, 0, 1, 32'h0, 32'h0, 5'd0);
        step();
        chk("halt_flag", 128'(memory_p.halt), 128'(1));
        chk("halt_valid", 128'(memory_p.valid), 128'(1));
        chk("halt_busy", 128'(mem_busy), 128'(0));

        // Stall, then ihit=0: the held instruction must not change.
        execute_p = mk(0, 0, 0, 32'h77, 32'h0, 5'd3);
        step();
        stall = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin stall = 0; ihit = 0; end
            execute_p = rand_ex();
            step();
            chk("hold_alu", 128'(memory_p.alu_out), 128'(32'h77));
            chk("hold_wsel", 128'(memory_p.wsel), 128'(3));
        end
        ihit = 1;
        execute_p = '0;
        step();

        // Back-to-back loads, dhit on the second request cycle of each.
        execute_p = mk(1, 0, 0, 32'h200, 32'd0, 5'd5);
        step();
        execute_p = mk(1, 0, 0, 32'h300, 32'd0, 5'd6);
        chk("b2b_a_addr", 128'(dmemaddr), 128'(32'h200));
        step();
        dhit = 1; dmemload = 32'h1111;
        step();
        chk("b2b_a_dload", 128'(memory_p.dload), 128'(32'h1111));
        chk("b2b_a_valid", 128'(memory_p.valid), 128'(1));
        chk("b2b_a_ren", 128'(dmemREN), 128'(0));
        dhit = 0;
        step();
        chk("b2b_b_ren", 128'(dmemREN), 128'(1));
        chk("b2b_b_addr", 128'(dmemaddr), 128'(32'h300));
        chk("b2b_b_hidden", 128'(memory_p.valid), 128'(0));
        execute_p = '0;
        step();
        dhit = 1; dmemload = 32'h2222;
        step();
        chk("b2b_b_dload", 128'(memory_p.dload), 128'(32'h2222));
        chk("b2b_b_wsel", 128'(memory_p.wsel), 128'(6));
        dmemload = 32'h0BAD;
        step();
        step();
        chk("idle_dhit_dload", 128'(memory_p.dload), 128'(32'h2222));
        chk("idle_dhit_busy", 128'(mem_busy), 128'(0));

        // Reset during an outstanding access abandons it.
        dhit = 0;
        execute_p = mk(1, 0, 0, 32'h500, 32'd0, 5'd7);
        step();
        chk("rstreq_ren", 128'(dmemREN), 128'(1));
        nRST = 0;
        execute_p = '0;
        step();
        all_zero("rstreq");
        nRST = 1;
        step();

        // Randomized run, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            nRST = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
